// File: rtl/llc_set_ctrl_pkg.sv
// Shared LLC line/set definitions: cache geometry defaults, derived field
// widths, MESI/op/FSM enums and the packed line and set records.
package llc_set_ctrl_pkg;

    localparam int DEF_ADDR_SIZE = 32;
    localparam int DEF_LINE_SIZE = 64;
    localparam int DEF_N_WAY     = 16;
    localparam int DEF_NUM_SETS  = 16384;

    function automatic int offset_width(input int line_size);
        return $clog2(line_size);
    endfunction

    function automatic int index_width(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_width(input int addr_size, input int line_size, input int num_sets);
        return addr_size - offset_width(line_size) - index_width(num_sets);
    endfunction

    // A binary tree over N ways has N-1 internal nodes.
    function automatic int plru_width(input int n_way);
        return n_way - 1;
    endfunction

    localparam int DEF_TAG_W  = tag_width(DEF_ADDR_SIZE, DEF_LINE_SIZE, DEF_NUM_SETS);
    localparam int DEF_PLRU_W = plru_width(DEF_N_WAY);

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_e;

    typedef enum logic [1:0] {
        OP_READ      = 2'b00,
        OP_WRITE     = 2'b01,
        OP_SNOOP_RD  = 2'b10,
        OP_SNOOP_INV = 2'b11
    } llc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_UPDATE,
        ST_RESP
    } llc_state_e;

    typedef struct packed {
        logic [DEF_TAG_W-1:0] tag;
        mesi_e                mesi;
        logic                 dirty;
        logic                 valid;
    } line_st;

    typedef struct packed {
        line_st [DEF_N_WAY-1:0] ways;
        logic   [DEF_PLRU_W-1:0] plru;
    } set_st;

endpackage

// File: rtl/llc_set_ctrl_plru.sv
// Tree pseudo-LRU: victim way from the node bits, and the node bits after a
// touch. Node i has children 2i+1 / 2i+2; a 0 bit sends the victim left.
module llc_plru_tree #(
    parameter int N_WAY = 16
) (
    input  logic [N_WAY-2:0]         bits,
    input  logic [$clog2(N_WAY)-1:0] touch_way,
    output logic [$clog2(N_WAY)-1:0] victim_way,
    output logic [N_WAY-2:0]         next_bits
);

    localparam int WAY_W = $clog2(N_WAY);

    // Level l holds nodes (2^l - 1) .. (2^(l+1) - 2); a way's top l bits pick
    // its node on that level, so every select below has an exact-width index.
    for (genvar l = 0; l < WAY_W; l++) begin : g_lvl
        localparam int BASE = (1 << l) - 1;
        localparam int CNT  = 1 << l;

        logic [CNT-1:0] lvl_bits;
        logic           dir;
        logic [l:0]     path;

        assign lvl_bits = bits[BASE +: CNT];

        if (l == 0) begin : g_top
            assign dir  = lvl_bits[0];
            assign path = dir;
        end else begin : g_sub
            assign dir  = lvl_bits[g_lvl[l-1].path];
            assign path = {g_lvl[l-1].path, dir};
        end

        for (genvar p = 0; p < CNT; p++) begin : g_node
            if (l == 0) begin : g_root
                assign next_bits[BASE] = ~touch_way[WAY_W-1];
            end else begin : g_inner
                localparam logic [WAY_W-1:0] POS = WAY_W'(p);
                assign next_bits[BASE+p] = (touch_way[WAY_W-1 -: l] == POS[l-1:0])
                                         ? ~touch_way[WAY_W-1-l] : bits[BASE+p];
            end
        end
    end

    assign victim_way = g_lvl[WAY_W-1].path;

endmodule

// File: rtl/llc_set_ctrl.sv
// LLC tag/state controller: one request at a time through
// IDLE -> LOOKUP -> UPDATE -> RESP, with MESI transitions and tree-PLRU.
module llc_set_ctrl
    import llc_set_ctrl_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int LINE_SIZE = DEF_LINE_SIZE,
    parameter int N_WAY     = DEF_N_WAY,
    parameter int NUM_SETS  = DEF_NUM_SETS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [ADDR_SIZE-1:0]     req_addr,
    input  logic                     req_shared,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_hit,
    output logic [$clog2(N_WAY)-1:0] resp_way,
    output logic [1:0]               resp_mesi,
    output logic                     resp_evict,
    output logic                     resp_wb,
    output logic [ADDR_SIZE-1:0]     resp_evict_addr
);

    localparam int OFFSET_W = offset_width(LINE_SIZE);
    localparam int INDEX_W  = index_width(NUM_SETS);
    localparam int TAG_W    = tag_width(ADDR_SIZE, LINE_SIZE, NUM_SETS);
    localparam int WAY_W    = $clog2(N_WAY);
    localparam int PLRU_W   = plru_width(N_WAY);

    typedef logic [N_WAY-1:0][TAG_W-1:0] tag_row_t;
    typedef logic [N_WAY-1:0][1:0]       mesi_row_t;

    llc_state_e state, state_next;

    llc_op_e            q_op;
    logic [TAG_W-1:0]   q_tag;
    logic [INDEX_W-1:0] q_idx;
    logic               q_shared;

    // NOTE: the arrays below are not reset; set_init marks which sets have
    // been written since reset, and an unwritten set reads as all-I, tag 0,
    // PLRU 0. This gives the reset state without clearing every entry.
    tag_row_t            tag_mem  [NUM_SETS];
    mesi_row_t           mesi_mem [NUM_SETS];
    logic [PLRU_W-1:0]   plru_mem [NUM_SETS];
    logic [NUM_SETS-1:0] set_init;

    tag_row_t          set_tags;
    mesi_row_t         set_mesi;
    logic [PLRU_W-1:0] set_plru;

    assign set_tags = set_init[q_idx] ? tag_mem[q_idx]  : '0;
    assign set_mesi = set_init[q_idx] ? mesi_mem[q_idx] : '0;
    assign set_plru = set_init[q_idx] ? plru_mem[q_idx] : '0;

    logic               lk_hit, free_found, lk_touch;
    logic [WAY_W-1:0]   hit_way, free_way, alloc_way, plru_victim, lk_way;
    mesi_e              lk_mesi, cur_mesi, victim_mesi;
    logic               lk_evict, lk_wb;
    logic [ADDR_SIZE-1:0] lk_evict_addr, line_addr;
    tag_row_t           lk_tag_row;
    mesi_row_t          lk_mesi_row;
    logic [PLRU_W-1:0]  plru_next, lk_plru_row;

    logic               r_hit, r_evict, r_wb;
    logic [WAY_W-1:0]   r_way;
    mesi_e              r_mesi;
    logic [ADDR_SIZE-1:0] r_evict_addr;
    tag_row_t           r_tag_row;
    mesi_row_t          r_mesi_row;
    logic [PLRU_W-1:0]  r_plru_row;

    logic unused_offset;
    assign unused_offset = ^req_addr[OFFSET_W-1:0];

    llc_plru_tree #(.N_WAY(N_WAY)) u_plru (
        .bits       (set_plru),
        .touch_way  (lk_way),
        .victim_way (plru_victim),
        .next_bits  (plru_next)
    );

    // NOTE: every always_comb output gets a default on entry so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        lk_hit     = 1'b0;
        hit_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = 0; w < N_WAY; w++) begin
            if (set_mesi[w] != MESI_I && set_tags[w] == q_tag) begin
                lk_hit  = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!free_found && set_mesi[w] == MESI_I) begin
                free_found = 1'b1;
                free_way   = WAY_W'(w);
            end
        end
    end

    assign alloc_way   = free_found ? free_way : plru_victim;
    assign cur_mesi    = mesi_e'(set_mesi[hit_way]);
    assign victim_mesi = mesi_e'(set_mesi[alloc_way]);
    assign line_addr   = {q_tag, q_idx, {OFFSET_W{1'b0}}};

    // NOTE: combinational blocks use blocking '=' so later statements see the
    // values computed above them; clocked blocks use '<=' only.
    always_comb begin
        lk_way        = '0;
        lk_mesi       = MESI_I;
        lk_evict      = 1'b0;
        lk_wb         = 1'b0;
        lk_evict_addr = '0;
        lk_touch      = 1'b0;
        lk_tag_row    = set_tags;
        lk_mesi_row   = set_mesi;
        case (q_op)
            OP_READ, OP_WRITE: begin
                lk_touch = 1'b1;
                if (lk_hit) begin
                    lk_way  = hit_way;
                    lk_mesi = (q_op == OP_WRITE) ? MESI_M : cur_mesi;
                end else begin
                    lk_way  = alloc_way;
                    lk_mesi = (q_op == OP_WRITE) ? MESI_M : (q_shared ? MESI_S : MESI_E);
                    lk_tag_row[alloc_way] = q_tag;
                    if (victim_mesi != MESI_I) begin
                        lk_evict      = 1'b1;
                        lk_wb         = (victim_mesi == MESI_M);
                        lk_evict_addr = {set_tags[alloc_way], q_idx, {OFFSET_W{1'b0}}};
                    end
                end
                lk_mesi_row[lk_way] = lk_mesi;
            end
            default: begin
                // Snoops: a miss leaves the set untouched and reports I.
                if (lk_hit) begin
                    lk_way  = hit_way;
                    lk_mesi = (q_op == OP_SNOOP_INV) ? MESI_I : MESI_S;
                    lk_mesi_row[hit_way] = lk_mesi;
                    if (cur_mesi == MESI_M) begin
                        lk_wb         = 1'b1;
                        lk_evict_addr = line_addr;
                    end
                end
            end
        endcase
    end

    assign lk_plru_row = lk_touch ? plru_next : set_plru;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (req_valid) state_next = ST_LOOKUP;
            ST_LOOKUP: state_next = ST_UPDATE;
            ST_UPDATE: state_next = ST_RESP;
            ST_RESP:   if (resp_ready) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            q_op         <= OP_READ;
            q_tag        <= '0;
            q_idx        <= '0;
            q_shared     <= 1'b0;
            r_hit        <= 1'b0;
            r_way        <= '0;
            r_mesi       <= MESI_I;
            r_evict      <= 1'b0;
            r_wb         <= 1'b0;
            r_evict_addr <= '0;
            r_tag_row    <= '0;
            r_mesi_row   <= '0;
            r_plru_row   <= '0;
            set_init     <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && req_valid) begin
                q_op     <= llc_op_e'(req_op);
                q_tag    <= req_addr[ADDR_SIZE-1 -: TAG_W];
                q_idx    <= req_addr[OFFSET_W +: INDEX_W];
                q_shared <= req_shared;
            end
            if (state == ST_LOOKUP) begin
                r_hit        <= lk_hit;
                r_way        <= lk_way;
                r_mesi       <= lk_mesi;
                r_evict      <= lk_evict;
                r_wb         <= lk_wb;
                r_evict_addr <= lk_evict_addr;
                r_tag_row    <= lk_tag_row;
                r_mesi_row   <= lk_mesi_row;
                r_plru_row   <= lk_plru_row;
            end
            if (state == ST_UPDATE) begin
                set_init[q_idx] <= 1'b1;
            end
        end
    end

    // Whole rows are written so a first write to a set also clears its
    // untouched ways.
    always_ff @(posedge clk) begin
        if (state == ST_UPDATE) begin
            tag_mem[q_idx]  <= r_tag_row;
            mesi_mem[q_idx] <= r_mesi_row;
            plru_mem[q_idx] <= r_plru_row;
        end
    end

    assign req_ready       = (state == ST_IDLE);
    assign resp_valid      = (state == ST_RESP);
    assign resp_hit        = r_hit;
    assign resp_way        = r_way;
    assign resp_mesi       = r_mesi;
    assign resp_evict      = r_evict;
    assign resp_wb         = r_wb;
    assign resp_evict_addr = r_evict_addr;

endmodule

// File: tb/tb_llc_set_ctrl.sv
// Self-checking bench for llc_set_ctrl: a vector table driven through a
// scoreboard, plus backpressure and mid-operation reset sequences.
module tb_llc_set_ctrl;
    import llc_set_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_addr = '0;
    logic        req_shared = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_hit;
    logic [3:0]  resp_way;
    logic [1:0]  resp_mesi;
    logic        resp_evict;
    logic        resp_wb;
    logic [31:0] resp_evict_addr;

    llc_set_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_shared      (req_shared),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_hit        (resp_hit),
        .resp_way        (resp_way),
        .resp_mesi       (resp_mesi),
        .resp_evict      (resp_evict),
        .resp_wb         (resp_wb),
        .resp_evict_addr (resp_evict_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        llc_op_e     op;
        logic [31:0] addr;
        logic        shared;
        logic        hit;
        logic [3:0]  way;
        mesi_e       mesi;
        logic        evict;
        logic        wb;
        logic [31:0] evict_addr;
        logic        chk_evict;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic vec_t mk(input llc_op_e op, input logic [31:0] addr, input logic shared,
                                input logic hit, input int way, input mesi_e mesi,
                                input logic evict, input logic wb, input logic [31:0] ea,
                                input logic chk_evict = 1'b1);
        vec_t v;
        v.op = op; v.addr = addr; v.shared = shared; v.hit = hit; v.way = 4'(way);
        v.mesi = mesi; v.evict = evict; v.wb = wb; v.evict_addr = ea; v.chk_evict = chk_evict;
        return v;
    endfunction

    task automatic compare_resp(input vec_t e, input string tag);
        check({tag, ".hit"},  32'(resp_hit),  32'(e.hit));
        check({tag, ".way"},  32'(resp_way),  32'(e.way));
        check({tag, ".mesi"}, 32'(resp_mesi), 32'(e.mesi));
        if (e.chk_evict) check({tag, ".evict"}, 32'(resp_evict), 32'(e.evict));
        check({tag, ".wb"},   32'(resp_wb),   32'(e.wb));
        check({tag, ".evict_addr"}, resp_evict_addr, e.evict_addr);
    endtask

    // Drive one request, score its response, optionally hold resp_ready low
    // for 'hold' cycles while offering a stray request that must be ignored.
    task automatic run_req(input vec_t v, input int hold, input string tag);
        vec_t e;
        int   lat;
        @(negedge clk);
        check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_op     = v.op;
        req_addr   = v.addr;
        req_shared = v.shared;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = $urandom;
        lat = 0;
        while (!resp_valid && lat < 16) begin
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        if (!resp_valid) begin
            check({tag, ".resp_timeout"}, 32'(resp_valid), 32'd1);
            return;
        end
        check({tag, ".latency"}, 32'(lat), 32'd3);
        compare_resp(e, tag);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            req_op    = OP_WRITE;
            req_addr  = 32'h0000_0080;
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(resp_valid), 32'd1);
            check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
            compare_resp(e, {tag, ".hold"});
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, ".ready_after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Default geometry: offset [5:0], index [19:6], tag [31:20].
        vecs.push_back(mk(OP_READ, 32'h0000_0040, 0, 0, 0, MESI_E, 0, 0, 32'h0));
        vecs.push_back(mk(OP_READ, 32'h0000_0040, 0, 1, 0, MESI_E, 0, 0, 32'h0));
        for (int t = 0; t < 16; t++)
            vecs.push_back(mk(OP_READ, 32'(t) << 20, 0, 0, t, MESI_E, 0, 0, 32'h0));
        vecs.push_back(mk(OP_READ, 32'h0100_0000, 0, 0, 0, MESI_E, 1, 0, 32'h0000_0000));
        vecs.push_back(mk(OP_WRITE, 32'h0000_0040, 0, 1, 0, MESI_M, 0, 0, 32'h0));
        vecs.push_back(mk(OP_SNOOP_RD, 32'h0000_0040, 0, 1, 0, MESI_S, 0, 1, 32'h0000_0040));
        vecs.push_back(mk(OP_WRITE, 32'h0000_0040, 0, 1, 0, MESI_M, 0, 0, 32'h0));
        vecs.push_back(mk(OP_SNOOP_INV, 32'h0000_0040, 0, 1, 0, MESI_I, 0, 1, 32'h0000_0040, 1'b0));
        vecs.push_back(mk(OP_READ, 32'h0000_0040, 0, 0, 0, MESI_E, 0, 0, 32'h0));
        vecs.push_back(mk(OP_SNOOP_RD, 32'h1234_5680, 0, 0, 0, MESI_I, 0, 0, 32'h0));
        // Set 0 victim is way 8 now; a snoop hit there must not move the PLRU.
        vecs.push_back(mk(OP_SNOOP_RD, 32'h0080_0000, 0, 1, 8, MESI_S, 0, 0, 32'h0));
        vecs.push_back(mk(OP_READ, 32'h0110_0000, 0, 0, 8, MESI_E, 1, 0, 32'h0080_0000));
        vecs.push_back(mk(OP_READ, 32'h0000_0080, 1, 0, 0, MESI_S, 0, 0, 32'h0));
        vecs.push_back(mk(OP_WRITE, 32'h0000_00C0, 0, 0, 0, MESI_M, 0, 0, 32'h0));
        for (int t = 0; t < 16; t++)
            vecs.push_back(mk(OP_WRITE, (32'(t) << 20) | 32'h140, 0, 0, t, MESI_M, 0, 0, 32'h0));
        vecs.push_back(mk(OP_WRITE, 32'h0100_0140, 0, 0, 0, MESI_M, 1, 1, 32'h0000_0140));
        vecs.push_back(mk(OP_READ, 32'h0000_0140, 0, 0, 8, MESI_E, 1, 1, 32'h0080_0140));

        repeat (3) @(negedge clk);
        check("rst.req_ready",  32'(req_ready),  32'd1);
        check("rst.resp_valid", 32'(resp_valid), 32'd0);
        check("rst.resp_hit",   32'(resp_hit),   32'd0);
        check("rst.resp_way",   32'(resp_way),   32'd0);
        check("rst.resp_mesi",  32'(resp_mesi),  32'd0);
        check("rst.resp_evict", 32'(resp_evict), 32'd0);
        check("rst.resp_wb",    32'(resp_wb),    32'd0);
        check("rst.evict_addr", resp_evict_addr, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_req(vecs[i], 0, $sformatf("vec%0d", i));

        run_req(mk(OP_READ, 32'h0100_0140, 0, 1, 0, MESI_M, 0, 0, 32'h0), 5, "backpressure");
        run_req(mk(OP_READ, 32'h0000_0080, 0, 1, 0, MESI_S, 0, 0, 32'h0), 0, "stray_ignored");

        // Reset while the controller sits in LOOKUP: request dropped.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_WRITE;
        req_addr  = 32'h0000_0080;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("midrst.busy", 32'(req_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst.req_ready",  32'(req_ready),  32'd1);
        check("midrst.resp_valid", 32'(resp_valid), 32'd0);
        check("midrst.resp_hit",   32'(resp_hit),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("midrst.no_resp", 32'(resp_valid), 32'd0);
        end
        run_req(mk(OP_READ, 32'h0000_0080, 0, 0, 0, MESI_E, 0, 0, 32'h0), 0, "post_rst_set2");
        run_req(mk(OP_READ, 32'h0100_0000, 0, 0, 0, MESI_E, 0, 0, 32'h0), 0, "post_rst_set0");
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
